// File: rtl/minmax_track_4bit_if.sv
// Stream interface for minmax_track_4bit: frame start, sample input handshake,
// result output handshake and the frame statistics.
interface minmax_track_4bit_if;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] max_out;
  logic [3:0] min_out;
  logic [3:0] max_hits;
  logic       busy;

  // Producer/consumer side driving the block
  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, max_out, min_out, max_hits, busy
  );

  // The tracker itself
  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, max_out, min_out, max_hits, busy
  );
endinterface

// File: rtl/minmax_track_4bit.sv
// minmax_track_4bit: collects a frame of N_SAMPLES unsigned 4-bit samples and
// reports the largest and smallest value of the frame.
// Optional feature: define MINMAX_HITS_EN to count how many samples of the
// frame equal the maximum (saturating at 15); otherwise max_hits is tied to 0.
module minmax_track_4bit #(
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  minmax_track_4bit_if.slave  bus
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] N_LAST = CW'(N_SAMPLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   max_q, max_d;
  logic [DW-1:0]   min_q, min_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic            accept_c;
  logic [CW-1:0]   cnt_inc_c;

  assign accept_c  = bus.in_valid & in_ready_q;
  assign cnt_inc_c = CW'(cnt_q + CNT_ONE);

  // Next-state, running min/max and registered handshake outputs
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    min_d       = min_q;
    cnt_d       = cnt_q;
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FIRST;
      end
      S_FIRST: begin
        if (accept_c) begin
          max_d   = bus.in_data;
          min_d   = bus.in_data;
          cnt_d   = CNT_ONE;
          state_d = (N_LAST == CNT_ONE) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          if (bus.in_data > max_q) max_d = bus.in_data;
          if (bus.in_data < min_q) min_d = bus.in_data;
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == N_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    in_ready_d  = (state_d == S_FIRST) || (state_d == S_RUN);
    busy_d      = (state_d == S_FIRST) || (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      max_q       <= '0;
      min_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      min_q       <= min_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MINMAX_HITS_EN
  localparam logic [DW-1:0] HITS_MAX = DW'(15);

  logic [DW-1:0] hits_q, hits_d;

  // Count of samples equal to the running maximum; a new maximum restarts it
  always_comb begin
    hits_d = hits_q;
    if (accept_c) begin
      if (state_q == S_FIRST) begin
        hits_d = DW'(1);
      end else if (state_q == S_RUN) begin
        if (bus.in_data > max_q) begin
          hits_d = DW'(1);
        end else if ((bus.in_data == max_q) && (hits_q != HITS_MAX)) begin
          hits_d = DW'(hits_q + DW'(1));
        end
      end
    end
  end

  // Hits register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hits_q <= '0;
    else        hits_q <= hits_d;
  end

  assign bus.max_hits = hits_q;
`else
  assign bus.max_hits = '0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.max_out   = max_q;
  assign bus.min_out   = min_q;

endmodule

// File: tb/tb_minmax_track_4bit.sv
// Bench for minmax_track_4bit: directed frames plus randomized frames with
// random input gaps and output backpressure, checked against a queue model.
module tb_minmax_track_4bit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  minmax_track_4bit_if if0();
  minmax_track_4bit_if if1();

  minmax_track_4bit #(.N_SAMPLES(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  minmax_track_4bit #(.N_SAMPLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] frame_q[$];

  // Reference model: statistics of the whole frame, computed directly
  function automatic logic [3:0] ref_max();
    int m = 0;
    foreach (frame_q[i]) if (int'(frame_q[i]) > m) m = int'(frame_q[i]);
    return 4'(m);
  endfunction

  function automatic logic [3:0] ref_min();
    int m = 15;
    foreach (frame_q[i]) if (int'(frame_q[i]) < m) m = int'(frame_q[i]);
    return 4'(m);
  endfunction

  function automatic logic [3:0] ref_hits();
`ifdef MINMAX_HITS_EN
    int h = 0;
    logic [3:0] mx = ref_max();
    foreach (frame_q[i]) if (frame_q[i] == mx) h++;
    if (h > 15) h = 15;
    return 4'(h);
`else
    return 4'd0;
`endif
  endfunction

  // mode 0: continuous valid, 1: alternate cycles, 2: random gaps
  task automatic drive_frame(input int mode);
    int idx = 0;
    int cyc = 0;
    bit acc;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (if0.busy !== 1'b1 || if0.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL first_state: busy=%b in_ready=%b expected 1/1", if0.busy, if0.in_ready);
    end
    while (idx < frame_q.size() && cyc < 200) begin
      case (mode)
        0:       if0.in_valid = 1'b1;
        1:       if0.in_valid = cyc[0];
        default: if0.in_valid = ($urandom_range(99) < 60);
      endcase
      if0.in_data = if0.in_valid ? frame_q[idx] : 4'($urandom_range(15));
      n_vec++;
      if (if0.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL early_out_valid: got %b expected 0 at sample %0d", if0.out_valid, idx);
      end
      acc = if0.in_valid && if0.in_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    if0.in_valid = 1'b0;
    n_vec++;
    if (idx != frame_q.size()) begin
      n_err++;
      $display("FAIL frame_timeout: accepted %0d expected %0d", idx, frame_q.size());
    end
    n_vec++;
    if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0 || if0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_latency: out_valid=%b in_ready=%b busy=%b expected 1/0/0",
               if0.out_valid, if0.in_ready, if0.busy);
    end
  endtask

  // Hold out_ready low for `hold` cycles, then release and check return to IDLE
  task automatic check_result(input int hold);
    logic [3:0] emax = ref_max();
    logic [3:0] emin = ref_min();
    logic [3:0] ehit = ref_hits();
    for (int i = 0; i <= hold; i++) begin
      n_vec++;
      if (if0.out_valid !== 1'b1 || if0.max_out !== emax || if0.min_out !== emin ||
          if0.max_hits !== ehit) begin
        n_err++;
        $display("FAIL result: ov=%b max=%0d min=%0d hits=%0d expected 1 %0d %0d %0d",
                 if0.out_valid, if0.max_out, if0.min_out, if0.max_hits, emax, emin, ehit);
      end
      if (i == hold) if0.out_ready = 1'b1;
      @(negedge clk);
    end
    if0.out_ready = 1'b0;
    n_vec++;
    if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b0 || if0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_idle: ov=%b in_ready=%b busy=%b expected 0/0/0",
               if0.out_valid, if0.in_ready, if0.busy);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b0 || if0.busy !== 1'b0 ||
        if0.max_out !== 4'd0 || if0.min_out !== 4'd0 || if0.max_hits !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: ov=%b rdy=%b busy=%b max=%0d min=%0d hits=%0d expected all 0",
               if0.out_valid, if0.in_ready, if0.busy, if0.max_out, if0.min_out, if0.max_hits);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (if0.busy !== 1'b0 || if1.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_wait: busy=%b/%b expected 0/0", if0.busy, if1.busy);
    end
  endtask

  task automatic test_full_frame();
    frame_q = '{4'd1, 4'd10, 4'd15, 4'd13, 4'd9, 4'd14, 4'd5, 4'd0};
    drive_frame(0);
    check_result(0);
  endtask

  task automatic test_all_equal();
    frame_q = '{8{4'd15}};
    drive_frame(0);
    check_result(1);
  endtask

  task automatic test_gaps_backpressure();
    frame_q.delete();
    repeat (8) frame_q.push_back(4'($urandom_range(15)));
    drive_frame(1);
    check_result(5);
  endtask

  task automatic test_midframe_reset();
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    repeat (3) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 4'($urandom_range(15));
      @(negedge clk);
    end
    if0.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b0 || if0.busy !== 1'b0 ||
        if0.max_out !== 4'd0 || if0.min_out !== 4'd0 || if0.max_hits !== 4'd0) begin
      n_err++;
      $display("FAIL midframe_reset: ov=%b rdy=%b busy=%b max=%0d min=%0d hits=%0d expected all 0",
               if0.out_valid, if0.in_ready, if0.busy, if0.max_out, if0.min_out, if0.max_hits);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (if0.out_valid !== 1'b0 || if0.busy !== 1'b0 || if0.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_idle: ov=%b busy=%b rdy=%b expected 0/0/0",
                 if0.out_valid, if0.busy, if0.in_ready);
      end
    end
    frame_q = '{4'd14, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    drive_frame(0);
    check_result(1);
  endtask

  task automatic test_single_sample();
    logic [3:0] ehit;
`ifdef MINMAX_HITS_EN
    ehit = 4'd1;
`else
    ehit = 4'd0;
`endif
    if1.start = 1'b1;
    @(negedge clk);
    if1.start    = 1'b0;
    if1.in_valid = 1'b1;
    if1.in_data  = 4'd9;
    @(negedge clk);
    if1.in_valid = 1'b0;
    n_vec++;
    if (if1.out_valid !== 1'b1 || if1.max_out !== 4'd9 || if1.min_out !== 4'd9 ||
        if1.max_hits !== ehit || if1.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single: ov=%b max=%0d min=%0d hits=%0d rdy=%b expected 1 9 9 %0d 0",
               if1.out_valid, if1.max_out, if1.min_out, if1.max_hits, if1.in_ready, ehit);
    end
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (if1.out_valid !== 1'b1 || if1.busy !== 1'b0 || if1.max_out !== 4'd9) begin
      n_err++;
      $display("FAIL start_in_done: ov=%b busy=%b max=%0d expected 1 0 9",
               if1.out_valid, if1.busy, if1.max_out);
    end
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (if1.out_valid !== 1'b0 || if1.busy !== 1'b0 || if1.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: ov=%b busy=%b rdy=%b expected 0/0/0",
               if1.out_valid, if1.busy, if1.in_ready);
    end
  endtask

  // Random frames issued back to back; narrow value ranges force equal maxima
  task automatic test_back_to_back();
    for (int f = 0; f < 12; f++) begin
      int lo = $urandom_range(15);
      int hi = lo + $urandom_range(15 - lo);
      frame_q.delete();
      repeat (8) frame_q.push_back(4'($urandom_range(hi, lo)));
      drive_frame(2);
      check_result($urandom_range(3));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    if0.start     = 1'b0;
    if0.in_valid  = 1'b0;
    if0.in_data   = 4'd0;
    if0.out_ready = 1'b0;
    if1.start     = 1'b0;
    if1.in_valid  = 1'b0;
    if1.in_data   = 4'd0;
    if1.out_ready = 1'b0;

    test_reset();
    test_full_frame();
    test_all_equal();
    test_gaps_backpressure();
    test_midframe_reset();
    test_single_sample();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/minmax_track_4bit.md
MINMAX_TRACK_4BIT -- requirements
Module: minmax_track_4bit

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8, giving the frame length in samples (legal range 1..15).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-005 SHALL have port in_valid  input  1  in_data holds a valid sample.
REQ-006 SHALL have port in_data  input  4  unsigned sample.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port out_valid  output  1  frame result available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port max_out  output  4  largest sample of the frame.
REQ-011 SHALL have port min_out  output  4  smallest sample of the frame.
REQ-012 SHALL have port max_hits  output  4  number of frame samples equal to max_out (see Configuration).
REQ-013 SHALL have port busy  output  1  high in FIRST and RUN.

Function
REQ-014 SHALL implement FSM states IDLE, FIRST, RUN, DONE, with all registers on rising clk.
REQ-015 SHALL accept a sample only on a cycle where in_valid and in_ready are both high; in_ready SHALL be high exactly in FIRST and RUN.
REQ-016 IDLE: start high -> FIRST next cycle; start is ignored in all other states.
REQ-017 FIRST: on acceptance, max=min=in_data, count=1, hits=1; -> DONE if N_SAMPLES==1, else -> RUN.
REQ-018 RUN: on acceptance, unsigned compare against max and min. If in_data > max, load max. If in_data < min, load min. Increment count by 1.
REQ-019 RUN: -> DONE on the cycle the accepted sample makes count equal N_SAMPLES; no extra sample SHALL be accepted.
REQ-020 Cycles without acceptance (in_valid low) SHALL leave all state unchanged.
REQ-021 DONE: out_valid high, with max_out, min_out and max_hits stable, until out_ready is high; then -> IDLE next cycle.
REQ-022 out_valid SHALL be registered and SHALL rise one cycle after the final sample's acceptance edge (latency 1).
REQ-023 max_out and min_out SHALL show the running values at all times; they are valid to consume only while out_valid is high.
REQ-024 Equal samples (in_data == max or == min) SHALL NOT change max or min.
REQ-025 All-equal frames SHALL give max_out == min_out.

Reset
REQ-026 rst_n low SHALL immediately force:
- state to IDLE;
- in_ready, out_valid, busy to 0;
- max_out, min_out, max_hits and the internal count to 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no out_valid pulse.
REQ-028 After reset deassertion the block SHALL wait in IDLE for start.

Configuration
REQ-029 Macro MINMAX_HITS_EN SHALL control the max_hits feature.
REQ-030 With MINMAX_HITS_EN defined:
- a sample with in_data > max SHALL set hits to 1;
- a sample with in_data == max SHALL increment hits, saturating at 15;
- max_hits SHALL output hits.
REQ-031 Without MINMAX_HITS_EN, the hits logic SHALL be absent, the max_hits port SHALL remain, and max_hits SHALL be driven constant 0.

Verification
REQ-032 The bench SHALL cover these scenarios (N_SAMPLES=8 unless stated):
- Full frame: start, then samples 1,10,15,13,9,14,5,0 with in_valid continuous -> out_valid one cycle after the 8th acceptance, max_out=15, min_out=0, max_hits=1 (0 without the macro).
- All equal: start, then 8 x 4'b1111 -> max_out=min_out=15, max_hits=8.
- Gaps and output backpressure: in_valid toggled every other cycle, out_ready held low 5 cycles -> out_valid stays high and outputs are stable; after out_ready, IDLE with in_ready=0.
- Mid-frame reset: rst_n pulsed low after 3 samples -> outputs 0 and IDLE, no out_valid; a fresh frame of 14,0,1,1,1,1,1,1 -> max_out=14, min_out=0.
- Single sample: N_SAMPLES=1, start then sample 9 -> max_out=min_out=9 with out_valid; start asserted during DONE is ignored.
